enc_dec_apb_regs: RTL and testbench

APB-side register bank and operation sequencer for the encoder/decoder datapath. It holds the four CPU-visible registers (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE) and launches one operation per accepted CTRL write. It waits for the core to finish, then captures the result and reports completion. It sits between the APB bus and the enc/dec core, and its register contents and done/result outputs are what the golden model is checked against.

---
 rtl/enc_dec_pkg.sv | 24 ++
 rtl/enc_dec_seq_fsm.sv | 90 +++++++++
 rtl/enc_dec_apb_regs.sv | 114 +++++++++++
 tb/tb_enc_dec_apb_regs.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/enc_dec_pkg.sv
// Shared constants and types for the enc/dec APB register bank.
//   REG_*  : register offsets as decoded from PADDR[3:2]
//   MODE_* : CTRL[1:0] operation modes; MODE_ILLEGAL is stored but never launched
//   state_e: sequencer FSM states
package enc_dec_pkg;

    localparam logic [1:0] REG_CTRL           = 2'b00;
    localparam logic [1:0] REG_DATA_IN        = 2'b01;
    localparam logic [1:0] REG_CODEWORD_WIDTH = 2'b10;
    localparam logic [1:0] REG_NOISE          = 2'b11;

    localparam logic [1:0] MODE_ENC     = 2'b00;
    localparam logic [1:0] MODE_DEC     = 2'b01;
    localparam logic [1:0] MODE_FULL    = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StStart = 2'b01,
        StBusy  = 2'b10,
        StDone  = 2'b11
    } state_e;

endpackage

// File: rtl/enc_dec_seq_fsm.sv
// Operation sequencer: IDLE -> START -> BUSY -> DONE -> IDLE.
// Ports:
//   clk, rst            clock, async active-low reset
//   launch              accepted legal CTRL write (only honoured in IDLE)
//   core_done           core completion strobe, sampled in BUSY only
//   core_data_out       core result, captured on BUSY->DONE
//   core_num_of_errors  core error count, captured on BUSY->DONE
//   idle                FSM in IDLE; gates register writes in the top
//   start               one-cycle launch pulse (START state)
//   busy                high in START and BUSY
//   operation_done      one-cycle completion pulse (DONE state)
//   data_out            captured result, held until the next DONE
//   num_of_errors       captured error count, held until the next DONE
module enc_dec_seq_fsm
    import enc_dec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  launch,
    input  logic                  core_done,
    input  logic [DATA_WIDTH-1:0] core_data_out,
    input  logic [1:0]            core_num_of_errors,
    output logic                  idle,
    output logic                  start,
    output logic                  busy,
    output logic                  operation_done,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            num_of_errors
);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic [1:0]              num_of_errors_q;
    logic                    capture;

    // Capture happens on the same edge that moves BUSY -> DONE.
    assign capture = (state_q == StBusy) && core_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            data_out_q      <= '0;
            num_of_errors_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                data_out_q      <= core_data_out;
                num_of_errors_q <= core_num_of_errors;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        idle           = 1'b0;
        start          = 1'b0;
        busy           = 1'b0;
        operation_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                idle = 1'b1;
                if (launch) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                start   = 1'b1;
                busy    = 1'b1;
                state_d = StBusy;
            end
            StBusy: begin
                busy = 1'b1;
                if (core_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                operation_done = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign data_out      = data_out_q;
    assign num_of_errors = num_of_errors_q;

endmodule

// File: rtl/enc_dec_apb_regs.sv
// APB register bank (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE) and operation launcher.
// Ports:
//   clk, rst                       clock, async active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request, zero wait states, PADDR[3:2] decoded
//   PRDATA                         read data, loaded at the read setup edge
//   start, busy, operation_done    sequencer status (see enc_dec_seq_fsm)
//   ctrl_reg .. noise_reg          live register contents to the core
//   core_done/core_data_out/core_num_of_errors  core completion interface
//   data_out, num_of_errors        captured core result
module enc_dec_apb_regs
    import enc_dec_pkg::*;
#(
    parameter int unsigned AMBA_ADDR_WIDTH = 20,
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       start,
    output logic [AMBA_WORD-1:0]       ctrl_reg,
    output logic [AMBA_WORD-1:0]       data_in_reg,
    output logic [AMBA_WORD-1:0]       codeword_width_reg,
    output logic [AMBA_WORD-1:0]       noise_reg,
    input  logic                       core_done,
    input  logic [DATA_WIDTH-1:0]      core_data_out,
    input  logic [1:0]                 core_num_of_errors,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic [1:0]                 num_of_errors,
    output logic                       operation_done,
    output logic                       busy
);

    logic [1:0]           addr_sel;
    logic                 idle;
    logic                 wr_en;
    logic                 rd_setup;
    logic                 launch;
    logic [AMBA_WORD-1:0] rd_mux;
    logic [AMBA_WORD-1:0] ctrl_q, data_in_q, codeword_width_q, noise_q, prdata_q;
    logic                 unused_paddr;

    assign addr_sel     = PADDR[3:2];
    assign unused_paddr = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0]};

    // Writes outside IDLE (including the DONE cycle) are dropped.
    assign wr_en    = PSEL && PENABLE && PWRITE && idle;
    assign rd_setup = PSEL && !PENABLE && !PWRITE;
    assign launch   = wr_en && (addr_sel == REG_CTRL) && (PWDATA[1:0] != MODE_ILLEGAL);

    always_comb begin
        rd_mux = '0;
        unique case (addr_sel)
            REG_CTRL:           rd_mux = ctrl_q;
            REG_DATA_IN:        rd_mux = data_in_q;
            REG_CODEWORD_WIDTH: rd_mux = codeword_width_q;
            REG_NOISE:          rd_mux = noise_q;
            default:            rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q           <= '0;
            data_in_q        <= '0;
            codeword_width_q <= '0;
            noise_q          <= '0;
            prdata_q         <= '0;
        end else begin
            if (wr_en) begin
                unique case (addr_sel)
                    REG_CTRL:           ctrl_q           <= PWDATA;
                    REG_DATA_IN:        data_in_q        <= PWDATA;
                    REG_CODEWORD_WIDTH: codeword_width_q <= PWDATA;
                    REG_NOISE:          noise_q          <= PWDATA;
                    default:            ;
                endcase
            end
            // Loaded at setup so PRDATA is stable for the whole access phase.
            if (rd_setup) begin
                prdata_q <= rd_mux;
            end
        end
    end

    assign PRDATA             = prdata_q;
    assign ctrl_reg           = ctrl_q;
    assign data_in_reg        = data_in_q;
    assign codeword_width_reg = codeword_width_q;
    assign noise_reg          = noise_q;

    enc_dec_seq_fsm #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_seq_fsm (
        .clk               (clk),
        .rst               (rst),
        .launch            (launch),
        .core_done         (core_done),
        .core_data_out     (core_data_out),
        .core_num_of_errors(core_num_of_errors),
        .idle              (idle),
        .start             (start),
        .busy              (busy),
        .operation_done    (operation_done),
        .data_out          (data_out),
        .num_of_errors     (num_of_errors)
    );

endmodule

// File: tb/tb_enc_dec_apb_regs.sv
// Directed self-checking bench for enc_dec_apb_regs.
module tb_enc_dec_apb_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        PSEL, PENABLE, PWRITE;
    logic [19:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        start;
    logic [31:0] ctrl_reg, data_in_reg, codeword_width_reg, noise_reg;
    logic        core_done;
    logic [31:0] core_data_out;
    logic [1:0]  core_num_of_errors;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic        operation_done, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;
    int n_done = 0;
    int s0, d0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start)          n_start <= n_start + 1;
        if (operation_done) n_done  <= n_done + 1;
    end

    enc_dec_apb_regs #(
        .AMBA_ADDR_WIDTH(20),
        .AMBA_WORD      (32),
        .DATA_WIDTH     (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .PSEL              (PSEL),
        .PENABLE           (PENABLE),
        .PWRITE            (PWRITE),
        .PADDR             (PADDR),
        .PWDATA            (PWDATA),
        .PRDATA            (PRDATA),
        .start             (start),
        .ctrl_reg          (ctrl_reg),
        .data_in_reg       (data_in_reg),
        .codeword_width_reg(codeword_width_reg),
        .noise_reg         (noise_reg),
        .core_done         (core_done),
        .core_data_out     (core_data_out),
        .core_num_of_errors(core_num_of_errors),
        .data_out          (data_out),
        .num_of_errors     (num_of_errors),
        .operation_done    (operation_done),
        .busy              (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Setup at one falling edge, access at the next; accepted on the rising edge between.
    task automatic apb_write(input logic [1:0] sel, input logic [31:0] data);
        @(negedge clk);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
        PADDR = {16'h0, sel, 2'b00}; PWDATA = data;
        @(negedge clk);
        PENABLE = 1'b1;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [1:0] sel, output logic [31:0] data);
        @(negedge clk);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0;
        PADDR = {16'h0, sel, 2'b00};
        @(negedge clk);
        PENABLE = 1'b1;
        data = PRDATA;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic pulse_core_done(input logic [31:0] dat, input logic [1:0] errs);
        core_done = 1'b1; core_data_out = dat; core_num_of_errors = errs;
        @(negedge clk);
        core_done = 1'b0; core_data_out = 32'h0; core_num_of_errors = 2'b00;
    endtask

    initial begin
        rst = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        core_done = 1'b0; core_data_out = '0; core_num_of_errors = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_start", {31'h0, start}, 32'h0);
        check("rst_data_out", data_out, 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apb_read(i[1:0], rd);
            check("rst_read", rd, 32'h0);
        end

        // Plain register writes, no operation launched
        apb_write(2'b01, 32'h0000_00A5);
        apb_write(2'b10, 32'h0000_0001);
        apb_write(2'b11, 32'h0000_0003);
        apb_read(2'b01, rd); check("rd_data_in", rd, 32'h0000_00A5);
        apb_read(2'b10, rd); check("rd_cw_width", rd, 32'h0000_0001);
        apb_read(2'b11, rd); check("rd_noise", rd, 32'h0000_0003);
        check("noise_reg_out", noise_reg, 32'h3);
        check("no_start_yet", n_start, 0);

        // core_done while IDLE is ignored
        pulse_core_done(32'hDEAD_BEEF, 2'b11);
        check("idle_done_ignored", {31'h0, operation_done}, 32'h0);
        check("idle_data_hold", data_out, 32'h0);

        // Full operation: CTRL=0x2, core answers three cycles after start
        apb_write(2'b00, 32'h0000_0002);
        check("op1_start", {31'h0, start}, 32'h1);
        check("op1_busy", {31'h0, busy}, 32'h1);
        check("op1_ctrl_reg", ctrl_reg, 32'h2);
        @(negedge clk);
        check("op1_start_1cyc", {31'h0, start}, 32'h0);
        check("op1_busy_hold", {31'h0, busy}, 32'h1);
        @(negedge clk);
        pulse_core_done(32'h0000_005A, 2'b10);
        check("op1_done", {31'h0, operation_done}, 32'h1);
        check("op1_data_out", data_out, 32'h5A);
        check("op1_errs", {30'h0, num_of_errors}, 32'h2);
        @(negedge clk);
        check("op1_done_1cyc", {31'h0, operation_done}, 32'h0);
        check("op1_idle", {31'h0, busy}, 32'h0);
        check("op1_data_hold", data_out, 32'h5A);
        check("op1_starts", n_start, 1);
        check("op1_dones", n_done, 1);

        // Writes while BUSY are dropped
        s0 = n_start; d0 = n_done;
        apb_write(2'b00, 32'h0000_0000);
        apb_write(2'b01, 32'hFFFF_FFFF);
        apb_write(2'b00, 32'h0000_0001);
        check("op2_still_busy", {31'h0, busy}, 32'h1);
        apb_read(2'b01, rd); check("op2_rd_data_in", rd, 32'h0000_00A5);
        apb_read(2'b00, rd); check("op2_rd_ctrl", rd, 32'h0);
        pulse_core_done(32'h0000_0033, 2'b01);
        check("op2_done", {31'h0, operation_done}, 32'h1);
        check("op2_data_out", data_out, 32'h33);
        check("op2_errs", {30'h0, num_of_errors}, 32'h1);
        repeat (3) @(negedge clk);
        check("op2_one_start", n_start - s0, 1);
        check("op2_one_done", n_done - d0, 1);

        // Illegal mode: stored, not launched
        s0 = n_start;
        apb_write(2'b00, 32'h0000_0003);
        check("ill_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        check("ill_no_start", n_start - s0, 0);
        apb_read(2'b00, rd); check("ill_rd_ctrl", rd, 32'h3);

        // Reset in the middle of BUSY, late core_done afterwards
        apb_write(2'b00, 32'h0000_0001);
        @(negedge clk);
        check("rst2_busy_pre", {31'h0, busy}, 32'h1);
        d0 = n_done;
        rst = 1'b0;
        #1;
        check("rst2_busy", {31'h0, busy}, 32'h0);
        check("rst2_prdata", PRDATA, 32'h0);
        check("rst2_data_out", data_out, 32'h0);
        check("rst2_errs", {30'h0, num_of_errors}, 32'h0);
        check("rst2_data_in_reg", data_in_reg, 32'h0);
        check("rst2_ctrl_reg", ctrl_reg, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse_core_done(32'h0000_0077, 2'b11);
        check("rst2_no_done", {31'h0, operation_done}, 32'h0);
        @(negedge clk);
        check("rst2_dones", n_done - d0, 0);
        check("rst2_idle", {31'h0, busy}, 32'h0);
        check("rst2_data_hold", data_out, 32'h0);
        check("rst2_cw_reg", codeword_width_reg, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
